// File: rtl/niu32_iter_alu.sv
// niu32_iter_alu: start/done execution unit with one-cycle simple ops and iterative multiply/divide.
// Defining NIU32_ITER_ALU_DIV_EN compiles in the restoring divider; otherwise DIV reports err.
module niu32_iter_alu #(
    parameter int WORD_SIZE = 32,
    parameter int OP_BITS   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_BITS-1:0]   func,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 err
);

    localparam int SH_W = $clog2(WORD_SIZE);
    localparam logic [SH_W-1:0] LAST_ITER = SH_W'(WORD_SIZE - 1);

    typedef logic [OP_BITS-1:0] op_t;
    localparam op_t OP_SUB = op_t'(0);
    localparam op_t OP_ADD = op_t'(1);
    localparam op_t OP_MLT = op_t'(2);
    localparam op_t OP_DIV = op_t'(3);
    localparam op_t OP_NOT = op_t'(4);
    localparam op_t OP_AND = op_t'(5);
    localparam op_t OP_OR  = op_t'(6);
    localparam op_t OP_XOR = op_t'(7);
    localparam op_t OP_SUL = op_t'(8);
    localparam op_t OP_SSL = op_t'(9);
    localparam op_t OP_SUR = op_t'(10);
    localparam op_t OP_SSR = op_t'(11);
    localparam op_t OP_EQ  = op_t'(16);
    localparam op_t OP_NEQ = op_t'(17);
    localparam op_t OP_LT  = op_t'(18);
    localparam op_t OP_LEQ = op_t'(19);

`ifdef NIU32_ITER_ALU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [SH_W-1:0]      cnt;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] work_a;
    logic [WORD_SIZE-1:0] work_b;
    logic [WORD_SIZE-1:0] simple_res;
    logic                 simple_err;
    logic [WORD_SIZE-1:0] mul_acc_nxt;
    logic                 accept;
    logic                 last_iter;
    logic                 cmp_bit;

    assign accept    = (state == S_IDLE) && start;
    assign last_iter = (cnt == LAST_ITER);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Shift-add step: work_a is the multiplicand moving left, work_b the multiplier moving right.
    assign mul_acc_nxt = acc + (work_b[0] ? work_a : '0);

`ifdef NIU32_ITER_ALU_DIV_EN
    logic                 neg_q;
    logic [WORD_SIZE-1:0] a_mag;
    logic [WORD_SIZE-1:0] b_mag;
    logic [WORD_SIZE:0]   div_shift;
    logic [WORD_SIZE:0]   div_trial;
    logic                 div_fit;
    logic [WORD_SIZE-1:0] rem_nxt;
    logic [WORD_SIZE-1:0] quo_nxt;

    // Magnitudes as unsigned values; |MIN| is representable, so MIN/-1 falls out as MIN.
    assign a_mag = a[WORD_SIZE-1] ? -a : a;
    assign b_mag = b[WORD_SIZE-1] ? -b : b;

    // Restoring step: acc holds the partial remainder, work_a shifts the dividend out and the quotient in.
    assign div_shift = {acc, work_a[WORD_SIZE-1]};
    assign div_trial = div_shift - {1'b0, work_b};
    assign div_fit   = ~div_trial[WORD_SIZE];
    assign rem_nxt   = div_fit ? div_trial[WORD_SIZE-1:0] : div_shift[WORD_SIZE-1:0];
    assign quo_nxt   = {work_a[WORD_SIZE-2:0], div_fit};
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        simple_res = '0;
        simple_err = 1'b0;
        cmp_bit    = 1'b0;
        case (func)
            OP_SUB: simple_res = a - b;
            OP_ADD: simple_res = a + b;
            OP_NOT: simple_res = ~a;
            OP_AND: simple_res = a & b;
            OP_OR:  simple_res = a | b;
            OP_XOR: simple_res = a ^ b;
            OP_SUL, OP_SSL: simple_res = a << b[SH_W-1:0];
            OP_SUR: simple_res = a >> b[SH_W-1:0];
            OP_SSR: simple_res = $signed(a) >>> b[SH_W-1:0];
            OP_EQ:  cmp_bit = (a == b);
            OP_NEQ: cmp_bit = (a != b);
            OP_LT:  cmp_bit = ($signed(a) <  $signed(b));
            OP_LEQ: cmp_bit = ($signed(a) <= $signed(b));
            // Iterative ops never take this path unless their hardware is absent.
            OP_MLT, OP_DIV: simple_err = 1'b1;
            default: simple_err = 1'b1;
        endcase
        if (func inside {OP_EQ, OP_NEQ, OP_LT, OP_LEQ}) begin
            simple_res = {{(WORD_SIZE-1){1'b0}}, cmp_bit};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (func == OP_MLT) begin
                        state_nxt = S_MUL;
`ifdef NIU32_ITER_ALU_DIV_EN
                    end else if (func == OP_DIV && b != '0) begin
                        state_nxt = S_DIV;
`endif
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_MUL: if (last_iter) state_nxt = S_DONE;
`ifdef NIU32_ITER_ALU_DIV_EN
            S_DIV: if (last_iter) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            work_a <= '0;
            work_b <= '0;
            result <= '0;
            err    <= 1'b0;
`ifdef NIU32_ITER_ALU_DIV_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        acc <= '0;
                        if (func == OP_MLT) begin
                            work_a <= a;
                            work_b <= b;
`ifdef NIU32_ITER_ALU_DIV_EN
                        end else if (func == OP_DIV) begin
                            if (b == '0) begin
                                result <= '1;
                                err    <= 1'b1;
                            end else begin
                                work_a <= a_mag;
                                work_b <= b_mag;
                                neg_q  <= a[WORD_SIZE-1] ^ b[WORD_SIZE-1];
                            end
`endif
                        end else begin
                            result <= simple_res;
                            err    <= simple_err;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_acc_nxt;
                    work_a <= work_a << 1;
                    work_b <= work_b >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        result <= mul_acc_nxt;
                        err    <= 1'b0;
                    end
                end
`ifdef NIU32_ITER_ALU_DIV_EN
                S_DIV: begin
                    acc    <= rem_nxt;
                    work_a <= quo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        result <= neg_q ? -quo_nxt : quo_nxt;
                        err    <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
